// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART transmitter.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int DEFAULT_FIFO_DEPTH   = 16;
    localparam int FRAME_BITS           = 10;
    localparam int DATA_BITS            = FRAME_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO. A push while full is dropped, even if a pop happens
// in the same cycle; the full flag is a plain occupancy compare.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign full      = (r_count == FULL_COUNT);
    assign empty     = (r_count == '0);
    assign level     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // NOTE: storage has no reset; pointers and count define validity, and
    // leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly AW bits, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a byte FIFO; frames are sent back to back
// with no idle gap while bytes remain queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_byte,
    input  logic                          send_request,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          idle,
    output logic                          tx
);

    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t     r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_overflow;

    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_rd_data;
    logic          w_pop;
    logic          w_bit_done;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (send_request),
        .wr_data (tx_byte),
        .pop     (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

    assign w_bit_done = (r_baud == BAUD_LAST);
    // The head is taken either from IDLE or on the last stop-bit cycle, which
    // is what gives zero idle time between consecutive frames.
    assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_done));

    assign busy     = w_full;
    assign overflow = r_overflow;
    assign idle     = (r_state == IDLE) && w_empty;
    assign tx       = r_tx;

    // NOTE: every state register here uses <= so all of them update from the
    // same pre-edge values; mixing in = would make results order-dependent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= send_request && w_full;
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_shift <= w_rd_data;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == BIT_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_rd_data;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_baud  <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one instance at default parameters, one at
// CLKS_PER_BIT=4 / FIFO_DEPTH=2.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] tx_byte_a;
    logic       send_request_a;
    logic       busy_a;
    logic       overflow_a;
    logic [4:0] level_a;
    logic       idle_a;
    logic       tx_a;

    logic [7:0] tx_byte_b;
    logic       send_request_b;
    logic       busy_b;
    logic       overflow_b;
    logic [1:0] level_b;
    logic       idle_b;
    logic       tx_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    uart_tx_fifo u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_byte      (tx_byte_a),
        .send_request (send_request_a),
        .busy         (busy_a),
        .overflow     (overflow_a),
        .level        (level_a),
        .idle         (idle_a),
        .tx           (tx_a)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (2)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_byte      (tx_byte_b),
        .send_request (send_request_b),
        .busy         (busy_b),
        .overflow     (overflow_b),
        .level        (level_b),
        .idle         (idle_b),
        .tx           (tx_b)
    );

    function automatic logic [31:0] f_tx(input int sel);
        return (sel == 0) ? 32'(tx_a) : 32'(tx_b);
    endfunction

    function automatic logic [31:0] f_level(input int sel);
        return (sel == 0) ? 32'(level_a) : 32'(level_b);
    endfunction

    function automatic logic [31:0] f_idle(input int sel);
        return (sel == 0) ? 32'(idle_a) : 32'(idle_b);
    endfunction

    function automatic logic [31:0] f_busy(input int sel);
        return (sel == 0) ? 32'(busy_a) : 32'(busy_b);
    endfunction

    function automatic logic [31:0] f_ovf(input int sel);
        return (sel == 0) ? 32'(overflow_a) : 32'(overflow_b);
    endfunction

    function automatic int cpb(input int sel);
        return (sel == 0) ? 104 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; requests are strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        send_request_a = 1'b0;
        send_request_b = 1'b0;
    endtask

    task automatic request(input int sel, input logic [7:0] data);
        if (sel == 0) begin
            tx_byte_a      = data;
            send_request_a = 1'b1;
        end else begin
            tx_byte_b      = data;
            send_request_b = 1'b1;
        end
    endtask

    // Called in the first cycle of a start bit; checks the first and last cycle
    // of every bit, and returns in the cycle after the stop bit.
    task automatic check_frame(input int sel, input logic [9:0] frame, input string tag);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("%s bit%0d first", tag, k), f_tx(sel), 32'(frame[k]));
            repeat (cpb(sel) - 1) tick();
            check($sformatf("%s bit%0d last", tag, k), f_tx(sel), 32'(frame[k]));
            tick();
        end
    endtask

    task automatic send_and_check(input int sel, input logic [7:0] data,
                                  input logic [9:0] frame, input string tag);
        request(sel, data);
        tick();
        check({tag, " tx high at N+1"}, f_tx(sel), 1);
        check({tag, " level at N+1"}, f_level(sel), 1);
        check({tag, " idle at N+1"}, f_idle(sel), 0);
        tick();
        check_frame(sel, frame, tag);
        check({tag, " idle after frame"}, f_idle(sel), 1);
    endtask

    initial begin
        tx_byte_a      = 8'h00;
        send_request_a = 1'b0;
        tx_byte_b      = 8'h00;
        send_request_b = 1'b0;

        vecs[0] = '{0, 8'h61, 10'h2C2};
        vecs[1] = '{0, 8'hA5, 10'h34A};
        vecs[2] = '{1, 8'h00, 10'h200};
        vecs[3] = '{1, 8'hFF, 10'h3FE};
        vecs[4] = '{1, 8'h3C, 10'h278};
        vecs[5] = '{1, 8'h61, 10'h2C2};

        // Reset state, and a request made while in reset must be ignored.
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset tx[%0d]", s), f_tx(s), 1);
            check($sformatf("reset level[%0d]", s), f_level(s), 0);
            check($sformatf("reset busy[%0d]", s), f_busy(s), 0);
            check($sformatf("reset overflow[%0d]", s), f_ovf(s), 0);
            check($sformatf("reset idle[%0d]", s), f_idle(s), 1);
        end
        request(0, 8'hEE);
        request(1, 8'hEE);
        tick();
        check("request in reset a", f_level(0), 0);
        check("request in reset b", f_level(1), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            send_and_check(vecs[i].sel, vecs[i].data, vecs[i].frame,
                           $sformatf("vec%0d", i));
        end

        // Three consecutive requests: three frames with no gap between them.
        request(0, 8'h41);
        tick();
        check("burst tx high at N+1", f_tx(0), 1);
        request(0, 8'h42);
        tick();
        request(0, 8'h43);
        check_frame(0, 10'h282, "burst0");
        check_frame(0, 10'h284, "burst1");
        check_frame(0, 10'h286, "burst2");
        check("burst idle after 3120", f_idle(0), 1);

        // Fill the FIFO: first byte pops at once, 16 stay queued.
        for (int i = 0; i < 17; i++) begin
            request(0, 8'h10 + 8'(i));
            tick();
        end
        check("full level", f_level(0), 16);
        check("full busy", f_busy(0), 1);
        check("full no overflow yet", f_ovf(0), 0);
        request(0, 8'hEE);
        tick();
        check("overflow pulse", f_ovf(0), 1);
        check("overflow level held", f_level(0), 16);
        tick();
        check("overflow one cycle", f_ovf(0), 0);
        repeat (1022) tick();
        // Last stop-bit cycle of the first frame: the pop happens now.
        check("pre-pop level", f_level(0), 16);
        check("pre-pop tx stop", f_tx(0), 1);
        request(0, 8'hDD);
        tick();
        check("concurrent pop overflow", f_ovf(0), 1);
        check("concurrent pop level", f_level(0), 15);
        check("next start bit", f_tx(0), 0);

        // Reset during data bit 3 of byte 0x11 (that bit is 0).
        repeat (466) tick();
        check("data bit3 before reset", f_tx(0), 0);
        check("queue before reset", f_level(0), 15);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset tx", f_tx(0), 1);
        check("async reset level", f_level(0), 0);
        check("async reset idle", f_idle(0), 1);
        check("async reset busy", f_busy(0), 0);
        request(0, 8'hEE);
        tick();
        check("reset ignores request", f_level(0), 0);
        rst_n = 1'b1;
        send_and_check(0, 8'h55, 10'h2AA, "post_reset");

        // Small instance: 2 queued after the first pop, 4th request overflows.
        request(1, 8'hA1);
        tick();
        request(1, 8'hA2);
        tick();
        request(1, 8'hA3);
        tick();
        check("small full level", f_level(1), 2);
        check("small busy", f_busy(1), 1);
        check("small tx in start", f_tx(1), 0);
        request(1, 8'hA4);
        tick();
        check("small overflow", f_ovf(1), 1);
        check("small level held", f_level(1), 2);
        repeat (117) tick();
        check("small not idle at 120", f_idle(1), 0);
        tick();
        check("small idle after 3 frames", f_idle(1), 1);
        check("small tx idle high", f_tx(1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
